// File: rtl/div_pkg.sv
// Shared types and constants for the divide controller and its sign-fix helper.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SPECIAL,
    S_DONE,
    S_DRAIN
  } div_state_e;

  localparam int unsigned WORD_W = 32;
  // Magnitude of the most negative 32-bit value, i.e. |-2^31| zero-extended.
  localparam logic [63:0] MOST_NEG_W_MAG = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate with optional 32-bit input extension and result sign-extension.
// Word handling exists only when DIV_CTRL_WORD_OPS_EN is defined.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] value,
  input  logic            negate,
`ifdef DIV_CTRL_WORD_OPS_EN
  input  logic            word,
  input  logic            ext_signed,
  input  logic            out_sext,
`endif
  output logic [XLEN-1:0] result
);

`ifdef DIV_CTRL_WORD_OPS_EN
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] flipped;

  // Extend before negating (operand magnitudes), sign-extend after negating (results):
  // a word magnitude of 2^31 must not be sign-extended.
  always_comb begin
    ext = value;
    if (word) begin
      ext = ext_signed ? XLEN'(signed'(value[WORD_W-1:0])) : XLEN'(value[WORD_W-1:0]);
    end
    flipped = negate ? -ext : ext;
    result  = flipped;
    if (word && out_sext) begin
      result = XLEN'(signed'(flipped[WORD_W-1:0]));
    end
  end
`else
  assign result = negate ? -value : value;
`endif

endmodule

// File: rtl/div_ctrl.sv
// Request-side controller for a multi-cycle unsigned divider: RV64M DIV/DIVU/REM/REMU.
// Define DIV_CTRL_WORD_OPS_EN to honour word_i (W-form operations).
module div_ctrl
  import div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            div_req_o,
  output logic [XLEN-1:0] div_op_a_o,
  output logic [XLEN-1:0] div_op_b_o,
  input  logic [XLEN-1:0] div_quotient_i,
  input  logic [XLEN-1:0] div_remainder_i,
  input  logic            div_done_i
);

  localparam logic [XLEN-1:0] MAG_ONE  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_reg, state_next;
  div_op_e    op_dec, op_reg;
  logic       neg_q_reg, neg_r_reg;
  logic [XLEN-1:0] sp_val_reg;

  logic            accept, is_signed, is_rem, div_zero, overflow, special, load_result;
  logic [1:0]      sign;
  logic [XLEN-1:0] raw [2];
  logic [XLEN-1:0] mag [2];
  logic [XLEN-1:0] most_neg_mag, sp_val, res_raw, res_fixed;
  logic            res_neg;

  assign op_dec    = div_op_e'(op_i);
  assign is_signed = (op_dec == OP_DIV) || (op_dec == OP_REM);
  assign is_rem    = (op_dec == OP_REM) || (op_dec == OP_REMU);
  assign accept    = req_i & gnt_o & ~flush_i;
  assign raw[0]    = op_a_i;
  assign raw[1]    = op_b_i;

`ifdef DIV_CTRL_WORD_OPS_EN
  logic word_reg;
  assign most_neg_mag = word_i ? XLEN'(MOST_NEG_W_MAG) : MOST_NEG;
`else
  logic unused_word;
  assign unused_word  = word_i;
  assign most_neg_mag = MOST_NEG;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_mag
`ifdef DIV_CTRL_WORD_OPS_EN
    assign sign[gi] = word_i ? raw[gi][WORD_W-1] : raw[gi][XLEN-1];
`else
    assign sign[gi] = raw[gi][XLEN-1];
`endif
    div_sign_fix #(.XLEN(XLEN)) u_mag (
      .value     (raw[gi]),
      .negate    (is_signed & sign[gi]),
`ifdef DIV_CTRL_WORD_OPS_EN
      .word      (word_i),
      .ext_signed(is_signed),
      .out_sext  (1'b0),
`endif
      .result    (mag[gi])
    );
  end

  // Special results go through the result sign-fix unnegated, so W-forms are still sign-extended.
  assign div_zero = (mag[1] == '0);
  assign overflow = is_signed & sign[0] & sign[1] & (mag[1] == MAG_ONE) & (mag[0] == most_neg_mag);
  assign special  = div_zero | overflow;
  assign sp_val   = is_rem ? (div_zero ? op_a_i : '0) : (div_zero ? '1 : op_a_i);

  always_comb begin
    res_raw = ((op_reg == OP_REM) || (op_reg == OP_REMU)) ? div_remainder_i : div_quotient_i;
    res_neg = ((op_reg == OP_REM) || (op_reg == OP_REMU)) ? neg_r_reg : neg_q_reg;
    if (state_reg == S_SPECIAL) begin
      res_raw = sp_val_reg;
      res_neg = 1'b0;
    end
  end

  div_sign_fix #(.XLEN(XLEN)) u_res (
    .value     (res_raw),
    .negate    (res_neg),
`ifdef DIV_CTRL_WORD_OPS_EN
    .word      (word_reg),
    .ext_signed(1'b1),
    .out_sext  (1'b1),
`endif
    .result    (res_fixed)
  );

  assign load_result = ~flush_i & (((state_reg == S_WAIT) & div_done_i) | (state_reg == S_SPECIAL));

  always_comb begin
    state_next = state_reg;
    gnt_o      = 1'b0;
    div_req_o  = 1'b0;
    valid_o    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        gnt_o = 1'b1;
        if (accept) state_next = special ? S_SPECIAL : S_ISSUE;
      end
      S_ISSUE: begin
        div_req_o  = 1'b1;
        state_next = S_WAIT;
        if (flush_i) state_next = div_done_i ? S_IDLE : S_DRAIN;
      end
      S_WAIT: begin
        if (flush_i)         state_next = div_done_i ? S_IDLE : S_DRAIN;
        else if (div_done_i) state_next = S_DONE;
      end
      S_SPECIAL: state_next = flush_i ? S_IDLE : S_DONE;
      S_DONE: begin
        valid_o    = ~flush_i;
        state_next = S_IDLE;
      end
      S_DRAIN: if (div_done_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= S_IDLE;
      op_reg     <= OP_DIV;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      sp_val_reg <= '0;
      div_op_a_o <= '0;
      div_op_b_o <= '0;
      result_o   <= '0;
`ifdef DIV_CTRL_WORD_OPS_EN
      word_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg     <= op_dec;
        neg_q_reg  <= is_signed & (sign[0] ^ sign[1]);
        neg_r_reg  <= is_signed & sign[0];
        sp_val_reg <= sp_val;
`ifdef DIV_CTRL_WORD_OPS_EN
        word_reg   <= word_i;
`endif
        // Divider operands are only reloaded on an issuing accept, so they hold until done.
        if (!special) begin
          div_op_a_o <= mag[0];
          div_op_b_o <= mag[1];
        end
      end
      if (load_result) result_o <= res_fixed;
    end
  end

endmodule
